// File: rtl/ultrasonic_pkg.sv
// Shared types and default timing for the ultrasonic scan controller.
// Defaults assume a 27 MHz board clock and HC-SR04 class rangers.
package ultrasonic_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_TRIG      = 3'd1,
      ST_WAIT_RISE = 3'd2,
      ST_WAIT_FALL = 3'd3,
      ST_GUARD     = 3'd4
   } state_t;

   localparam int DEF_NUM_SENS    = 4;
   localparam int DEF_US_DIV      = 27;
   localparam int DEF_TRIG_US     = 10;
   localparam int DEF_RISE_TO_US  = 30000;
   localparam int DEF_MAX_ECHO_US = 30000;
   localparam int DEF_GUARD_US    = 60000;
   localparam int DEF_CNT_W       = 16;

   // A single sensor still needs a 1-bit index port.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Free-running 1 us prescaler plus the clk-domain reset for the controller:
// reset asserts asynchronously and releases two clocks after nrst rises.
module us_tick_gen
   import ultrasonic_pkg::*;
#(
   parameter int US_DIV = DEF_US_DIV
) (
   input  logic clk,
   input  logic nrst,
   output logic o_tick,
   output logic o_rst_b
);

   localparam int PW = (US_DIV > 1) ? $clog2(US_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(US_DIV - 1);

   logic [PW-1:0] r_pre;
   logic [1:0]    r_rst_pipe;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_rst_pipe <= '0;
      end else begin
         r_rst_pipe <= {r_rst_pipe[0], 1'b1};
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_pre <= '0;
      end else if (r_pre == PRE_LAST) begin
         r_pre <= '0;
      end else begin
         r_pre <= r_pre + 1'b1;
      end
   end

   assign o_tick  = (r_pre == PRE_LAST);
   assign o_rst_b = r_rst_pipe[1];

endmodule

// File: rtl/ultrasonic_scan_ctrl.sv
// Round-robin scheduler sharing one trigger/echo timing engine between
// NUM_SENS ultrasonic rangers, with per-sensor result registers.
//
// state        | meaning
// ST_IDLE      | parked; starts a slot on the first tick with en high
// ST_TRIG      | trigger[cur_idx] high for TRIG_US
// ST_WAIT_RISE | waiting for echo rise, gives up after RISE_TO_US
// ST_WAIT_FALL | timing echo width in us, saturates at MAX_ECHO_US
// ST_GUARD     | crosstalk dead time, then cur_idx advances
module ultrasonic_scan_ctrl
   import ultrasonic_pkg::*;
#(
   parameter int  NUM_SENS    = DEF_NUM_SENS,
   parameter int  US_DIV      = DEF_US_DIV,
   parameter int  TRIG_US     = DEF_TRIG_US,
   parameter int  RISE_TO_US  = DEF_RISE_TO_US,
   parameter int  MAX_ECHO_US = DEF_MAX_ECHO_US,
   parameter int  GUARD_US    = DEF_GUARD_US,
   parameter int  CNT_W       = DEF_CNT_W,
   localparam int SW          = idx_width(NUM_SENS)
) (
   input  logic                clk,
   input  logic                nrst,
   input  logic                en,
   input  logic [NUM_SENS-1:0] echo,
   output logic [NUM_SENS-1:0] trigger,
   output logic [SW-1:0]       cur_idx,
   output logic                busy,
   output logic                meas_valid,
   output logic [SW-1:0]       meas_idx,
   output logic [CNT_W-1:0]    meas_data,
   output logic                meas_err,
   input  logic [SW-1:0]       rd_idx,
   output logic [CNT_W-1:0]    rd_data,
   output logic                rd_err
);

   localparam logic [CNT_W-1:0] TRIG_LAST  = CNT_W'(TRIG_US - 1);
   localparam logic [CNT_W-1:0] RISE_LAST  = CNT_W'(RISE_TO_US - 1);
   localparam logic [CNT_W-1:0] ECHO_MAX   = CNT_W'(MAX_ECHO_US);
   localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_US - 1);
   localparam logic [SW-1:0]    IDX_LAST   = SW'(NUM_SENS - 1);

   logic                w_tick;
   logic                w_rst_b;
   state_t              r_state;
   state_t              w_state_nxt;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic [SW-1:0]       r_cur_idx;
   logic [NUM_SENS-1:0] r_echo_meta;
   logic [NUM_SENS-1:0] r_echo_sync;
   logic                r_echo_prev;
   logic                w_echo_cur;
   logic                w_rise;
   logic                w_fall;
   logic                w_commit;
   logic                w_commit_err;
   logic [CNT_W-1:0]    w_commit_data;
   logic                w_advance;
   logic [NUM_SENS-1:0] w_trig;
   logic                r_meas_valid;
   logic [SW-1:0]       r_meas_idx;
   logic [CNT_W-1:0]    r_meas_data;
   logic                r_meas_err;
   logic [CNT_W-1:0]    r_res_data [NUM_SENS];
   logic [NUM_SENS-1:0] r_res_err;

   us_tick_gen #(.US_DIV(US_DIV)) u_tick_gen (
      .clk     (clk),
      .nrst    (nrst),
      .o_tick  (w_tick),
      .o_rst_b (w_rst_b)
   );

   // Edge history restarts on a new sensor so the old line cannot fake an edge.
   always_ff @(posedge clk or negedge w_rst_b) begin
      if (!w_rst_b) begin
         r_echo_meta <= '0;
         r_echo_sync <= '0;
         r_echo_prev <= 1'b0;
      end else begin
         r_echo_meta <= echo;
         r_echo_sync <= r_echo_meta;
         r_echo_prev <= w_advance ? 1'b0 : w_echo_cur;
      end
   end

   assign w_echo_cur = r_echo_sync[r_cur_idx];
   assign w_rise     = ~r_echo_prev & w_echo_cur;
   assign w_fall     = r_echo_prev & ~w_echo_cur;

   always_ff @(posedge clk or negedge w_rst_b) begin
      if (!w_rst_b) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_cur_idx <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_advance) begin
            r_cur_idx <= (r_cur_idx == IDX_LAST) ? '0 : r_cur_idx + 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_commit      = 1'b0;
      w_commit_err  = 1'b0;
      w_commit_data = '0;
      w_advance     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (en && w_tick) begin
               w_state_nxt = ST_TRIG;
               w_cnt_nxt   = '0;
            end
         end
         ST_TRIG: begin
            if (w_tick) begin
               if (r_cnt == TRIG_LAST) begin
                  w_state_nxt = ST_WAIT_RISE;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
         end
         ST_WAIT_RISE: begin
            if (w_rise) begin
               w_state_nxt = ST_WAIT_FALL;
               w_cnt_nxt   = '0;
            end else if (w_tick) begin
               if (r_cnt == RISE_LAST) begin
                  w_commit     = 1'b1;
                  w_commit_err = 1'b1;
                  w_state_nxt  = ST_GUARD;
                  w_cnt_nxt    = '0;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
         end
         ST_WAIT_FALL: begin
            // A fall wins over saturation in the same clock.
            if (w_fall) begin
               w_commit      = 1'b1;
               w_commit_data = r_cnt;
               w_state_nxt   = ST_GUARD;
               w_cnt_nxt     = '0;
            end else if (r_cnt == ECHO_MAX) begin
               w_commit      = 1'b1;
               w_commit_err  = 1'b1;
               w_commit_data = ECHO_MAX;
               w_state_nxt   = ST_GUARD;
               w_cnt_nxt     = '0;
            end else if (w_tick) begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ST_GUARD: begin
            if (w_tick) begin
               if (r_cnt == GUARD_LAST) begin
                  w_advance   = 1'b1;
                  w_state_nxt = ST_IDLE;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge w_rst_b) begin
      if (!w_rst_b) begin
         r_meas_valid <= 1'b0;
         r_meas_idx   <= '0;
         r_meas_data  <= '0;
         r_meas_err   <= 1'b0;
      end else begin
         r_meas_valid <= w_commit;
         if (w_commit) begin
            r_meas_idx  <= r_cur_idx;
            r_meas_data <= w_commit_data;
            r_meas_err  <= w_commit_err;
         end
      end
   end

   always_ff @(posedge clk or negedge w_rst_b) begin
      if (!w_rst_b) begin
         for (int i = 0; i < NUM_SENS; i++) begin
            r_res_data[i] <= '0;
         end
         r_res_err <= '0;
      end else if (w_commit) begin
         r_res_data[r_cur_idx] <= w_commit_data;
         r_res_err[r_cur_idx]  <= w_commit_err;
      end
   end

   // Decoded straight from state so reset drops the trigger without a clock.
   always_comb begin
      w_trig = '0;
      if (r_state == ST_TRIG) begin
         w_trig[r_cur_idx] = 1'b1;
      end
   end

   assign trigger    = w_trig;
   assign cur_idx    = r_cur_idx;
   assign busy       = (r_state != ST_IDLE);
   assign meas_valid = r_meas_valid;
   assign meas_idx   = r_meas_idx;
   assign meas_data  = r_meas_data;
   assign meas_err   = r_meas_err;
   assign rd_data    = r_res_data[rd_idx];
   assign rd_err     = r_res_err[rd_idx];

endmodule

// File: tb/tb_ultrasonic_scan_ctrl.sv
// Directed bench for ultrasonic_scan_ctrl: sensor echo model, trigger watcher
// and a result scoreboard fed with expected commits ahead of each scan round.
module tb_ultrasonic_scan_ctrl;

   localparam int NS      = 4;
   localparam int DIV     = 4;
   localparam int TRIG    = 10;
   localparam int RISE_TO = 100;
   localparam int MAXE    = 500;
   localparam int GUARD   = 50;

   logic          clk = 1'b0;
   logic          nrst = 1'b1;
   logic          en = 1'b0;
   logic [NS-1:0] echo;
   logic [NS-1:0] trigger;
   logic [1:0]    cur_idx;
   logic          busy;
   logic          meas_valid;
   logic [1:0]    meas_idx;
   logic [15:0]   meas_data;
   logic          meas_err;
   logic [1:0]    rd_idx = '0;
   logic [15:0]   rd_data;
   logic          rd_err;

   ultrasonic_scan_ctrl #(
      .NUM_SENS(NS), .US_DIV(DIV), .TRIG_US(TRIG), .RISE_TO_US(RISE_TO),
      .MAX_ECHO_US(MAXE), .GUARD_US(GUARD), .CNT_W(16)
   ) dut (
      .clk(clk), .nrst(nrst), .en(en), .echo(echo), .trigger(trigger),
      .cur_idx(cur_idx), .busy(busy), .meas_valid(meas_valid),
      .meas_idx(meas_idx), .meas_data(meas_data), .meas_err(meas_err),
      .rd_idx(rd_idx), .rd_data(rd_data), .rd_err(rd_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int idx;
      int data;
      int tol;
      int err;
      int lat;   // clk from trigger fall to meas_valid, in us; -1 = unchecked
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   mode   [NS];   // 0 echo after dly/wid, 1 silent, 2 stuck high
   int   dly_us [NS];
   int   wid_us [NS];
   int   last_fall_cyc = 0;
   int   last_commit_cyc = 0;
   bit   have_commit = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic chk_rng(input string tag, input logic [31:0] obs, input int lo, input int hi);
      n_vec++;
      assert ((obs >= lo) && (obs <= hi)) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
      end
   endtask

   task automatic push_exp(input int idx, input int data, input int tol, input int err, input int lat);
      exp_t e;
      e.idx = idx; e.data = data; e.tol = tol; e.err = err; e.lat = lat;
      sb.push_back(e);
   endtask

   task automatic set_sens(input int i, input int m, input int d, input int w);
      mode[i] = m; dly_us[i] = d; wid_us[i] = w;
   endtask

   task automatic chk_rd(input int idx, input int data, input int tol, input int err);
      rd_idx = 2'(idx);
      #1;
      chk_rng($sformatf("rd_data[%0d]", idx), rd_data, data - tol, data + tol);
      chk($sformatf("rd_err[%0d]", idx), rd_err, err);
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, sb.size(), 0);
   endtask

   // Sensor model: echo starts dly_us after the trigger falls, lasts wid_us.
   initial begin : sensor_model
      logic [NS-1:0] prev_trig;
      int dcnt [NS];
      int wcnt [NS];
      bit armed [NS];
      echo = '0;
      prev_trig = '0;
      for (int i = 0; i < NS; i++) begin
         dcnt[i] = 0; wcnt[i] = 0; armed[i] = 1'b0;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < NS; i++) begin
            if (!nrst) begin
               armed[i] = 1'b0;
            end else if (prev_trig[i] && !trigger[i] && mode[i] == 0) begin
               armed[i] = 1'b1;
               dcnt[i] = dly_us[i] * DIV;
               wcnt[i] = wid_us[i] * DIV;
            end
            if (mode[i] == 2) begin
               echo[i] = 1'b1;
            end else if (armed[i]) begin
               if (dcnt[i] > 0) begin
                  dcnt[i]--;
               end else if (wcnt[i] > 0) begin
                  echo[i] = 1'b1;
                  wcnt[i]--;
               end else begin
                  echo[i] = 1'b0;
                  armed[i] = 1'b0;
               end
            end else begin
               echo[i] = 1'b0;
            end
         end
         prev_trig = trigger;
      end
   end

   initial begin : trig_watch
      logic [NS-1:0] prev;
      logic [NS-1:0] want;
      int exp_idx;
      int rise_cyc;
      prev = '0;
      exp_idx = 0;
      rise_cyc = 0;
      forever begin
         @(negedge clk);
         if (!nrst) begin
            exp_idx = 0;
         end else begin
            if (busy) chk_rng("trig_at_most_one", $countones(trigger), 0, 1);
            if (prev == '0 && trigger != '0) begin
               want = '0;
               want[exp_idx] = 1'b1;
               chk("trig_order", trigger, want);
               if (have_commit) chk_rng("slot_gap", cyc - last_commit_cyc, GUARD * DIV, 1000000);
               exp_idx = (exp_idx + 1) % NS;
               rise_cyc = cyc;
            end else if (prev != '0 && trigger == '0) begin
               chk("trig_width", cyc - rise_cyc, TRIG * DIV);
               last_fall_cyc = cyc;
            end
         end
         prev = trigger;
      end
   end

   initial begin : meas_mon
      exp_t e;
      forever begin
         @(negedge clk);
         if (!nrst) begin
            have_commit = 1'b0;
         end else if (meas_valid) begin
            if (sb.size() == 0) begin
               chk("meas_unexpected", meas_valid, 1'b0);
            end else begin
               e = sb.pop_front();
               chk("meas_idx", meas_idx, e.idx);
               chk("meas_err", meas_err, e.err);
               chk_rng("meas_data", meas_data, e.data - e.tol, e.data + e.tol);
               if (e.lat >= 0) chk("meas_latency", cyc - last_fall_cyc, e.lat * DIV);
            end
            last_commit_cyc = cyc;
            have_commit = 1'b1;
         end
      end
   end

   initial begin : main
      int n;
      for (int i = 0; i < NS; i++) set_sens(i, 1, 0, 0);
      #2 nrst = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_trigger", trigger, 0);
      chk("rst_cur_idx", cur_idx, 0);
      chk("rst_busy", busy, 0);
      chk("rst_meas_valid", meas_valid, 0);
      for (int i = 0; i < NS; i++) chk_rd(i, 0, 0, 0);
      @(negedge clk);
      nrst = 1'b1;
      repeat (5) @(negedge clk);

      // Round 1: single measurement on 0, rotation, no echo on 2.
      set_sens(0, 0, 20, 300);
      set_sens(1, 0, 10, 200);
      set_sens(2, 1, 0, 0);
      set_sens(3, 0, 5, 400);
      push_exp(0, 300, 1, 0, -1);
      push_exp(1, 200, 1, 0, -1);
      push_exp(2, 0, 0, 1, RISE_TO);
      push_exp(3, 400, 1, 0, -1);
      en = 1'b1;
      wait_drain("round1_drain", 20000);
      chk_rd(0, 300, 1, 0);
      chk_rd(1, 200, 1, 0);
      chk_rd(2, 0, 0, 1);
      chk_rd(3, 400, 1, 0);

      // Round 2: 100/300/400 echoes, sensor 1 stuck high before its trigger.
      set_sens(0, 0, 15, 100);
      set_sens(1, 2, 0, 0);
      set_sens(2, 0, 10, 300);
      set_sens(3, 0, 10, 400);
      push_exp(0, 100, 1, 0, -1);
      push_exp(1, 0, 0, 1, RISE_TO);
      push_exp(2, 300, 1, 0, -1);
      push_exp(3, 400, 1, 0, -1);
      wait_drain("round2_drain", 20000);
      chk_rd(0, 100, 1, 0);
      chk_rd(1, 0, 0, 1);
      chk_rd(2, 300, 1, 0);
      chk_rd(3, 400, 1, 0);

      // Round 3: saturation on 1, then en drops while 2 is timing its echo.
      set_sens(0, 1, 0, 0);
      set_sens(1, 0, 10, 800);
      set_sens(2, 0, 10, 300);
      push_exp(0, 0, 0, 1, RISE_TO);
      push_exp(1, MAXE, 0, 1, -1);
      push_exp(2, 300, 1, 0, -1);
      n = 0;
      while (!(echo[2] && cur_idx == 2'd2) && n < 20000) begin
         @(negedge clk);
         n++;
      end
      chk("wait_echo2", echo[2], 1);
      repeat (100) @(negedge clk);
      en = 1'b0;
      wait_drain("round3_drain", 5000);
      n = 0;
      while (busy && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("en_off_busy", busy, 0);
      chk("en_off_cur_idx", cur_idx, 3);
      chk_rd(1, MAXE, 0, 1);
      chk_rd(2, 300, 1, 0);
      repeat (1000) @(negedge clk);
      chk("en_off_still_idle", busy, 0);
      chk("en_off_idx_held", cur_idx, 3);

      // Resume at 3, then reset in the middle of its trigger pulse.
      set_sens(3, 1, 0, 0);
      en = 1'b1;
      n = 0;
      while (!trigger[3] && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("resume_trigger3", trigger, 4'b1000);
      repeat (10) @(negedge clk);
      #2 nrst = 1'b0;
      #1;
      chk("rst_mid_trigger", trigger, 0);
      chk("rst_mid_cur_idx", cur_idx, 0);
      chk("rst_mid_busy", busy, 0);
      for (int i = 0; i < NS; i++) chk_rd(i, 0, 0, 0);
      en = 1'b0;
      repeat (3) @(negedge clk);
      nrst = 1'b1;
      repeat (50) @(negedge clk);
      chk("post_rst_idle", busy, 0);

      // After reset the scan restarts at sensor 0.
      push_exp(0, 0, 0, 1, RISE_TO);
      en = 1'b1;
      wait_drain("post_rst_drain", 3000);
      en = 1'b0;
      repeat (20) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
